// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
// Shared types for the ALU issue stage:
//   - rv32i_base_instr_type / rv32i_base_instr : decoded instruction format and opcode
//   - issue_state_e                            : occupancy of the issue skid buffer
//   - issue_entry_t                            : one captured instruction with selected operands
// The optional writeback bypass is controlled by the ALU_ISSUE_FWD_EN macro in alu_issue_stage.
package alu_issue_stage_pkg;

    localparam int unsigned ISSUE_DATA_W = 32;
    localparam int unsigned ISSUE_REG_W  = 5;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } rv32i_base_instr_type;

    typedef enum logic [5:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LUI, AUIPC,
        JAL, JALR,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } issue_state_e;

    typedef struct packed {
        rv32i_base_instr_type    instr_type;
        rv32i_base_instr         opcode;
        logic [ISSUE_DATA_W-1:0] pc;
        logic [ISSUE_DATA_W-1:0] a;
        logic [ISSUE_DATA_W-1:0] b;
        logic [ISSUE_DATA_W-1:0] imm;
        logic [ISSUE_DATA_W-1:0] rs2_val;
        logic [ISSUE_REG_W-1:0]  rd;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_stage_operand_sel.sv
// alu_operand_sel
// Combinational ALU operand select for one decoded RV32I instruction.
// Ports:
//   type_i, opcode_i       : instruction format and opcode
//   pc_i, rs1_val_i,
//   rs2_val_i, imm_i       : candidate operand sources (rs values already bypassed)
//   a_o, b_o               : selected ALU operands
module alu_operand_sel
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ISSUE_DATA_W
) (
    input  rv32i_base_instr_type  type_i,
    input  rv32i_base_instr       opcode_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_val_i,
    input  logic [DATA_WIDTH-1:0] rs2_val_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o
);

    always_comb begin
        a_o = rs1_val_i;
        b_o = imm_i;
        unique case (type_i)
            R_TYPE, B_TYPE: begin
                a_o = rs1_val_i;
                b_o = rs2_val_i;
            end
            I_TYPE, S_TYPE: begin
                a_o = rs1_val_i;
                b_o = imm_i;
            end
            U_TYPE: begin
                // LUI adds the immediate to zero, AUIPC to the PC.
                a_o = (opcode_i == LUI) ? '0 : pc_i;
                b_o = imm_i;
            end
            J_TYPE: begin
                // JAL computes the link address pc + 4.
                a_o = pc_i;
                b_o = DATA_WIDTH'(32'd4);
            end
            default: begin
                a_o = rs1_val_i;
                b_o = imm_i;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Registered issue stage in front of the ALU. Captures one decoded instruction per
// cycle, selects operands a/b and presents them from a registered main entry. A
// second (skid) entry absorbs one instruction while execute stalls, so in_ready_o
// depends only on registered state. flush_i empties the stage and drops any
// same-cycle input.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   in_valid_i / in_ready_o, in_type_i, in_opcode_i, in_pc_i, in_rs1_val_i,
//   in_rs2_val_i, in_rs1_i, in_rs2_i, in_rd_i, in_imm_i : decode side
//   wb_valid_i, wb_rd_i, wb_data_i : writeback bypass
//   out_valid_o / out_ready_i, a_o, b_o, type_o, opcode_o, pc_o, imm_o,
//   rs2_val_o, rd_o : execute side
// Configuration:
//   ALU_ISSUE_FWD_EN : when defined, writeback data replaces rs1/rs2 values at
//                      capture if wb_rd_i matches (x0 never bypasses). When not
//                      defined, wb_* are ignored.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = ISSUE_DATA_W,
    parameter int unsigned REG_ADDR_WIDTH = ISSUE_REG_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,

    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  rv32i_base_instr_type      in_type_i,
    input  rv32i_base_instr           in_opcode_i,
    input  logic [DATA_WIDTH-1:0]     in_pc_i,
    input  logic [DATA_WIDTH-1:0]     in_rs1_val_i,
    input  logic [DATA_WIDTH-1:0]     in_rs2_val_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_i,
    input  logic [DATA_WIDTH-1:0]     in_imm_i,

    input  logic                      wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,

    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     a_o,
    output logic [DATA_WIDTH-1:0]     b_o,
    output rv32i_base_instr_type      type_o,
    output rv32i_base_instr           opcode_o,
    output logic [DATA_WIDTH-1:0]     pc_o,
    output logic [DATA_WIDTH-1:0]     imm_o,
    output logic [DATA_WIDTH-1:0]     rs2_val_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_o
);

    issue_state_e          state_q, state_d;
    issue_entry_t          main_q, main_d;
    issue_entry_t          skid_q, skid_d;
    issue_entry_t          in_entry;

    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic                  accept;
    logic                  xfer;

`ifdef ALU_ISSUE_FWD_EN
    always_comb begin
        rs1_fwd = in_rs1_val_i;
        rs2_fwd = in_rs2_val_i;
        if (wb_valid_i && (wb_rd_i != '0) && (wb_rd_i == in_rs1_i)) begin
            rs1_fwd = wb_data_i;
        end
        if (wb_valid_i && (wb_rd_i != '0) && (wb_rd_i == in_rs2_i)) begin
            rs2_fwd = wb_data_i;
        end
    end
`else
    logic unused_fwd;
    assign rs1_fwd    = in_rs1_val_i;
    assign rs2_fwd    = in_rs2_val_i;
    assign unused_fwd = ^{wb_valid_i, wb_rd_i, wb_data_i, in_rs1_i, in_rs2_i};
`endif

    alu_operand_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_operand_sel (
        .type_i    (in_type_i),
        .opcode_i  (in_opcode_i),
        .pc_i      (in_pc_i),
        .rs1_val_i (rs1_fwd),
        .rs2_val_i (rs2_fwd),
        .imm_i     (in_imm_i),
        .a_o       (sel_a),
        .b_o       (sel_b)
    );

    always_comb begin
        in_entry            = '0;
        in_entry.instr_type = in_type_i;
        in_entry.opcode     = in_opcode_i;
        in_entry.pc         = in_pc_i;
        in_entry.a          = sel_a;
        in_entry.b          = sel_b;
        in_entry.imm        = in_imm_i;
        in_entry.rs2_val    = rs2_fwd;
        in_entry.rd         = in_rd_i;
    end

    // Handshake flags come from registered state only.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign accept      = in_valid_i & in_ready_o & ~flush_i;
    assign xfer        = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = FULL;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush wins over every other event; stale data in the entries is harmless
        // because the state says they are empty.
        if (flush_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign a_o       = main_q.a;
    assign b_o       = main_q.b;
    assign type_o    = main_q.instr_type;
    assign opcode_o  = main_q.opcode;
    assign pc_o      = main_q.pc;
    assign imm_o     = main_q.imm;
    assign rs2_val_o = main_q.rs2_val;
    assign rd_o      = main_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 flush_i = 1'b0;
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    rv32i_base_instr_type in_type_i = R_TYPE;
    rv32i_base_instr      in_opcode_i = ADD;
    logic [31:0]          in_pc_i = '0;
    logic [31:0]          in_rs1_val_i = '0;
    logic [31:0]          in_rs2_val_i = '0;
    logic [4:0]           in_rs1_i = '0;
    logic [4:0]           in_rs2_i = '0;
    logic [4:0]           in_rd_i = '0;
    logic [31:0]          in_imm_i = '0;
    logic                 wb_valid_i = 1'b0;
    logic [4:0]           wb_rd_i = '0;
    logic [31:0]          wb_data_i = '0;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b0;
    logic [31:0]          a_o, b_o, pc_o, imm_o, rs2_val_o;
    rv32i_base_instr_type type_o;
    rv32i_base_instr      opcode_o;
    logic [4:0]           rd_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        int unsigned ty;
        int unsigned op;
        logic [31:0] pc, a, b, imm, rs2v;
        logic [4:0]  rd;
    } exp_t;

    exp_t model_q[$];

    alu_issue_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_type_i    (in_type_i),
        .in_opcode_i  (in_opcode_i),
        .in_pc_i      (in_pc_i),
        .in_rs1_val_i (in_rs1_val_i),
        .in_rs2_val_i (in_rs2_val_i),
        .in_rs1_i     (in_rs1_i),
        .in_rs2_i     (in_rs2_i),
        .in_rd_i      (in_rd_i),
        .in_imm_i     (in_imm_i),
        .wb_valid_i   (wb_valid_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .a_o          (a_o),
        .b_o          (b_o),
        .type_o       (type_o),
        .opcode_o     (opcode_o),
        .pc_o         (pc_o),
        .imm_o        (imm_o),
        .rs2_val_o    (rs2_val_o),
        .rd_o         (rd_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // What the stage should capture from the current inputs, straight from the
    // operand-selection rules.
    function automatic exp_t model_capture();
        exp_t e;
        logic [31:0] r1 = in_rs1_val_i;
        logic [31:0] r2 = in_rs2_val_i;
`ifdef ALU_ISSUE_FWD_EN
        if (wb_valid_i && wb_rd_i != 0 && wb_rd_i == in_rs1_i) r1 = wb_data_i;
        if (wb_valid_i && wb_rd_i != 0 && wb_rd_i == in_rs2_i) r2 = wb_data_i;
`endif
        e.ty   = int'(in_type_i);
        e.op   = int'(in_opcode_i);
        e.pc   = in_pc_i;
        e.imm  = in_imm_i;
        e.rs2v = r2;
        e.rd   = in_rd_i;
        e.a    = r1;
        e.b    = in_imm_i;
        if (in_type_i == R_TYPE || in_type_i == B_TYPE) e.b = r2;
        else if (in_type_i == U_TYPE) e.a = (in_opcode_i == LUI) ? 32'd0 : in_pc_i;
        else if (in_type_i == J_TYPE) begin
            e.a = in_pc_i;
            e.b = 32'd4;
        end
        return e;
    endfunction

    task automatic check_outputs();
        int sz = model_q.size();
        check_eq("out_valid", out_valid_o, sz > 0);
        check_eq("in_ready", in_ready_o, sz < 2);
        if (sz > 0) begin
            check_eq("a", a_o, model_q[0].a);
            check_eq("b", b_o, model_q[0].b);
            check_eq("type", type_o, model_q[0].ty);
            check_eq("opcode", opcode_o, model_q[0].op);
            check_eq("pc", pc_o, model_q[0].pc);
            check_eq("imm", imm_o, model_q[0].imm);
            check_eq("rs2_val", rs2_val_o, model_q[0].rs2v);
            check_eq("rd", rd_o, model_q[0].rd);
        end
    endtask

    // Advance one clock with the inputs currently applied, update the FIFO model,
    // then check the outputs on the falling edge.
    task automatic step();
        int sz = model_q.size();
        bit acc = in_valid_i && (sz < 2) && !flush_i;
        bit xf  = (sz > 0) && out_ready_i;
        exp_t e = model_capture();
        if (flush_i) model_q.delete();
        else begin
            if (xf) void'(model_q.pop_front());
            if (acc) model_q.push_back(e);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic drive(input bit v, input rv32i_base_instr_type t, input rv32i_base_instr op,
                         input logic [31:0] pc, input logic [31:0] r1v, input logic [31:0] r2v,
                         input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd);
        in_valid_i   = v;
        in_type_i    = t;
        in_opcode_i  = op;
        in_pc_i      = pc;
        in_rs1_val_i = r1v;
        in_rs2_val_i = r2v;
        in_imm_i     = imm;
        in_rs1_i     = r1;
        in_rs2_i     = r2;
        in_rd_i      = rd;
    endtask

    task automatic drive_idle();
        drive(1'b0, R_TYPE, ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        // Reset state
        #1;
        check_eq("rst_out_valid", out_valid_o, 0);
        check_eq("rst_in_ready", in_ready_o, 1);
        check_eq("rst_a", a_o, 0);
        check_eq("rst_type", type_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check_outputs();

        // Basic operand selection
        out_ready_i = 1'b1;
        drive(1'b1, R_TYPE, ADD, 32'h0, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
        step();
        check_eq("add_valid", out_valid_o, 1);
        check_eq("add_a", a_o, 32'd5);
        check_eq("add_b", b_o, 32'd7);
        check_eq("add_type", type_o, R_TYPE);
        drive(1'b1, U_TYPE, AUIPC, 32'h100, 32'd9, 32'd9, 32'h2000, 5'd1, 5'd2, 5'd4);
        step();
        check_eq("auipc_a", a_o, 32'h100);
        check_eq("auipc_b", b_o, 32'h2000);
        drive(1'b1, U_TYPE, LUI, 32'h104, 32'd9, 32'd9, 32'h12345000, 5'd1, 5'd2, 5'd5);
        step();
        check_eq("lui_a", a_o, 32'd0);
        check_eq("lui_b", b_o, 32'h12345000);
        drive(1'b1, J_TYPE, JAL, 32'h40, 32'd9, 32'd9, 32'h80, 5'd0, 5'd0, 5'd1);
        step();
        check_eq("jal_a", a_o, 32'h40);
        check_eq("jal_b", b_o, 32'd4);
        drive_idle();
        step();

        // Back-pressure: three inputs while execute stalls
        out_ready_i = 1'b0;
        drive(1'b1, I_TYPE, ADDI, 32'd1, 32'd10, 32'd0, 32'd1, 5'd1, 5'd0, 5'd1);
        step();
        drive(1'b1, I_TYPE, ADDI, 32'd2, 32'd20, 32'd0, 32'd2, 5'd1, 5'd0, 5'd2);
        step();
        check_eq("bp_full_ready", in_ready_o, 0);
        drive(1'b1, I_TYPE, ADDI, 32'd3, 32'd30, 32'd0, 32'd3, 5'd1, 5'd0, 5'd3);
        step();
        check_eq("bp_hold_pc", pc_o, 32'd1);
        out_ready_i = 1'b1;
        step();
        check_eq("bp_order2", pc_o, 32'd2);
        step();
        check_eq("bp_order3", pc_o, 32'd3);
        drive_idle();
        step();
        check_eq("bp_drained", out_valid_o, 0);

        // Flush while full with a valid input present
        out_ready_i = 1'b0;
        drive(1'b1, S_TYPE, SW, 32'h10, 32'd1, 32'd2, 32'd8, 5'd1, 5'd2, 5'd0);
        step();
        drive(1'b1, S_TYPE, SW, 32'h14, 32'd3, 32'd4, 32'd12, 5'd1, 5'd2, 5'd0);
        step();
        drive(1'b1, R_TYPE, SUB, 32'h99, 32'd5, 32'd6, 32'd0, 5'd1, 5'd2, 5'd7);
        flush_i = 1'b1;
        step();
        check_eq("flush_valid", out_valid_o, 0);
        check_eq("flush_ready", in_ready_o, 1);
        flush_i = 1'b0;
        drive_idle();
        out_ready_i = 1'b1;
        step();
        check_eq("flush_dropped", out_valid_o, 0);

        // Writeback bypass
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        wb_data_i  = 32'hDEAD;
        drive(1'b1, I_TYPE, ADDI, 32'h20, 32'd0, 32'd0, 32'd1, 5'd3, 5'd0, 5'd4);
        step();
`ifdef ALU_ISSUE_FWD_EN
        check_eq("fwd_a", a_o, 32'hDEAD);
`else
        check_eq("nofwd_a", a_o, 32'd0);
`endif
        wb_rd_i = 5'd0;
        drive(1'b1, I_TYPE, ADDI, 32'h24, 32'd0, 32'd0, 32'd1, 5'd0, 5'd0, 5'd4);
        step();
        check_eq("x0_nofwd_a", a_o, 32'd0);
        wb_valid_i = 1'b0;
        drive_idle();
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [2:0] t = 3'($urandom_range(0, 7));
            rv32i_base_instr op = rv32i_base_instr'($urandom_range(0, 39));
            if (t == 3'(U_TYPE)) op = $urandom_range(0, 1) ? LUI : AUIPC;
            drive($urandom_range(0, 9) < 7, rv32i_base_instr_type'(t), op, $urandom, $urandom,
                  $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom));
            out_ready_i = $urandom_range(0, 9) < 6;
            flush_i     = $urandom_range(0, 19) == 0;
            wb_valid_i  = $urandom_range(0, 1);
            wb_rd_i     = 5'($urandom_range(0, 7));
            wb_data_i   = $urandom;
            step();
        end
        flush_i    = 1'b0;
        wb_valid_i = 1'b0;

        // Asynchronous reset while full
        out_ready_i = 1'b0;
        drive(1'b1, R_TYPE, XOR, 32'h200, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3);
        step();
        step();
        step();
        check_eq("pre_rst_full", in_ready_o, 0);
        #2;
        rst_i = 1'b1;
        #1;
        model_q.delete();
        check_eq("arst_valid", out_valid_o, 0);
        check_eq("arst_ready", in_ready_o, 1);
        check_eq("arst_a", a_o, 0);
        check_eq("arst_b", b_o, 0);
        check_eq("arst_pc", pc_o, 0);
        check_eq("arst_type", type_o, 0);
        check_eq("arst_opcode", opcode_o, 0);
        drive_idle();
        @(negedge clk_i);
        rst_i = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
